// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state encoding
// and the width helper used to size address and pointer fields.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    // Ceiling log2, never below 1 so a field always has at least one bit.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_select.sv
// Combinational round-robin picker: first set request bit scanning upward
// from the pointer, wrapping at the top index back to zero.
module reg_write_arbiter_rr_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-bank write path: picks one pending requester, drives
// its data onto the bus with a one-cycle register enable, then acknowledges.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int NUM_REGS = 4,
    parameter  int WIDTH    = 8,
    localparam int ADDR_W   = clog2_f(NUM_REGS),
    localparam int PTR_W    = clog2_f(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [WIDTH-1:0]          bus_data,
    output logic [NUM_REGS-1:0]       reg_en,
    output logic                      busy
);

    arb_state_e          state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    winner_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [WIDTH-1:0]    bus_data_q;
    logic [NUM_REGS-1:0] reg_en_q;
    logic                busy_q;

    logic [PTR_W-1:0]    sel_winner;
    logic                sel_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [WIDTH-1:0]    sel_data;
    logic [PTR_W-1:0]    rr_ptr_d;

    reg_write_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (sel_winner),
        .valid  (sel_valid)
    );

    always_comb begin
        sel_addr = req_addr[int'(sel_winner)*ADDR_W +: ADDR_W];
        sel_data = req_data[int'(sel_winner)*WIDTH +: WIDTH];
        rr_ptr_d = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    end

    // Address and data are captured only on the IDLE->WRITE edge; later
    // request changes cannot disturb a transfer already in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            grant_q    <= '0;
            bus_data_q <= '0;
            reg_en_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_q <= '0;
                    if (sel_valid) begin
                        winner_q   <= sel_winner;
                        bus_data_q <= sel_data;
                        reg_en_q   <= NUM_REGS'(1) << sel_addr;
                        busy_q     <= 1'b1;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    reg_en_q <= '0;
                    grant_q  <= NUM_REQ'(1) << winner_q;
                    state_q  <= ACK;
                end
                ACK: begin
                    grant_q  <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    grant_q  <= '0;
                    reg_en_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign bus_data = bus_data_q;
    assign reg_en   = reg_en_q;
    assign busy     = busy_q;

endmodule
